id_ex_hazard_reg: RTL and testbench

- ID/EX pipeline register for the 5-stage MIPS pipeline, directly downstream of the decode control unit; latches its control bundle and the decoded operands into EX each cycle.
- Owns load-use and jr-dependency hazard detection: freezes PC and IF/ID and injects a bubble into EX. Also honours a flush and keeps a saturating stall counter.

---
 rtl/id_ex_hazard_reg_pkg.sv | 31 +++
 rtl/id_ex_hazard_reg_hazard_detect.sv | 45 ++++
 rtl/id_ex_hazard_reg.sv | 122 ++++++++++++
 tb/tb_id_ex_hazard_reg.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_hazard_reg_pkg.sv
// Purpose: shared control-bundle layout and encodings for the ID/EX stage.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Contents: id_ctrl bit positions, reg_dst encodings, the jal link register.
package id_ex_hazard_reg_pkg;

  // id_ctrl = {reg_write, alu_src, mem_read, mem_write,
  //            mem_to_reg[1:0], reg_dst[1:0], alu_ctrl[2:0]}
  localparam int CTRL_W              = 11;
  localparam int CTRL_REG_WRITE      = 10;
  localparam int CTRL_ALU_SRC        = 9;
  localparam int CTRL_MEM_READ       = 8;
  localparam int CTRL_MEM_WRITE      = 7;
  localparam int CTRL_MEM_TO_REG_MSB = 6;
  localparam int CTRL_MEM_TO_REG_LSB = 5;
  localparam int CTRL_REG_DST_MSB    = 4;
  localparam int CTRL_REG_DST_LSB    = 3;
  localparam int CTRL_ALU_CTRL_MSB   = 2;
  localparam int CTRL_ALU_CTRL_LSB   = 0;

  typedef enum logic [1:0] {
    REG_DST_RT   = 2'b00,
    REG_DST_RD   = 2'b01,
    REG_DST_LINK = 2'b10,
    REG_DST_ZERO = 2'b11
  } reg_dst_e;

  // jal writes its return address here.
  localparam int LINK_REG = 31;

endpackage

// File: rtl/id_ex_hazard_reg_hazard_detect.sv
// Purpose: combinational load-use and jr-dependency hazard detection.
// Latency: zero cycles (pure combinational).
// Backpressure: stall asserted means PC and IF/ID freeze and EX takes a bubble.
// Ports: EX-stage mem_read/reg_write/dst, ID-stage rs/rt/uses_rt/is_jr,
//        MEM-stage load flag and dst, flush; outputs hz_ld, hz_jr, stall.
module id_ex_hazard_reg_hazard_detect #(
  parameter int RA_W = 5
) (
  input  logic            ex_mem_read,
  input  logic            ex_reg_write,
  input  logic [RA_W-1:0] ex_dst,
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rt,
  input  logic            id_uses_rt,
  input  logic            id_is_jr,
  input  logic            mem_mem_read,
  input  logic [RA_W-1:0] mem_dst,
  input  logic            flush,
  output logic            hz_ld,
  output logic            hz_jr,
  output logic            stall
);

  logic ex_dst_nz;
  logic rs_nz;

  assign ex_dst_nz = (ex_dst != '0);
  assign rs_nz     = (id_rs != '0);

  // Load in EX feeding a source of the ID instruction; $0 is never a real
  // dependency.
  assign hz_ld = ex_mem_read & ex_dst_nz &
                 ((ex_dst == id_rs) | (id_uses_rt & (ex_dst == id_rt)));

  // jr resolves its target in ID, so it must wait for any producer still in
  // EX, and additionally for a load in MEM (its data is not ready until WB).
  assign hz_jr = id_is_jr & rs_nz &
                 ((ex_reg_write & (ex_dst == id_rs)) |
                  (mem_mem_read & (mem_dst == id_rs)));

  // A flushed decode instruction is discarded anyway, so stalling for it
  // would only waste a cycle.
  assign stall = (hz_ld | hz_jr) & ~flush;

endmodule

// File: rtl/id_ex_hazard_reg.sv
// Purpose: ID/EX pipeline register with hazard-driven bubble insertion and flush.
// Latency: one cycle ID->EX.
// Backpressure: on a hazard pc_write/if_id_write drop the same cycle and EX gets a bubble.
// Ports: clk/rst (sync, active high); id_* decode bundle in; mem_* EX/MEM
//        lookahead; flush; ex_* registered bundle out; pc_write, if_id_write
//        (combinational); stall_count (saturating bubble count).
module id_ex_hazard_reg
  import id_ex_hazard_reg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_is_jr,
  input  logic              id_uses_rt,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [RA_W-1:0]   id_rs,
  input  logic [RA_W-1:0]   id_rt,
  input  logic [RA_W-1:0]   id_rd,
  input  logic              flush,
  input  logic              mem_reg_write,
  input  logic              mem_mem_read,
  input  logic [RA_W-1:0]   mem_dst,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [RA_W-1:0]   ex_rs,
  output logic [RA_W-1:0]   ex_rt,
  output logic [RA_W-1:0]   ex_dst,
  output logic              pc_write,
  output logic              if_id_write,
  output logic [CNT_W-1:0]  stall_count
);

  logic            hz_ld;
  logic            hz_jr;
  logic            stall;
  logic [RA_W-1:0] dst_nxt;
  reg_dst_e        reg_dst_sel;

  // A load in MEM is identified by mem_mem_read alone; the write flag is
  // carried on the interface but adds no information here.
  logic unused_mem_reg_write;
  assign unused_mem_reg_write = mem_reg_write;

  id_ex_hazard_reg_hazard_detect #(
    .RA_W(RA_W)
  ) u_hazard_detect (
    .ex_mem_read  (ex_ctrl[CTRL_MEM_READ]),
    .ex_reg_write (ex_ctrl[CTRL_REG_WRITE]),
    .ex_dst       (ex_dst),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .id_is_jr     (id_is_jr),
    .mem_mem_read (mem_mem_read),
    .mem_dst      (mem_dst),
    .flush        (flush),
    .hz_ld        (hz_ld),
    .hz_jr        (hz_jr),
    .stall        (stall)
  );

  // Freeze signals are purely combinational so the front end holds in the
  // very cycle the hazard is seen; reset does not touch them.
  assign pc_write    = ~stall;
  assign if_id_write = ~stall;

  assign reg_dst_sel = reg_dst_e'(id_ctrl[CTRL_REG_DST_MSB:CTRL_REG_DST_LSB]);

  always_comb begin
    dst_nxt = '0;
    unique case (reg_dst_sel)
      REG_DST_RT:   dst_nxt = id_rt;
      REG_DST_RD:   dst_nxt = id_rd;
      REG_DST_LINK: dst_nxt = RA_W'(LINK_REG);
      REG_DST_ZERO: dst_nxt = '0;
      default:      dst_nxt = '0;
    endcase
  end

  // Only the control bundle is cleared for flush/bubble: a zero bundle is a
  // NOP, so the data fields simply hold and never need an extra mux input.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_ctrl     <= '0;
      ex_rd1      <= '0;
      ex_rd2      <= '0;
      ex_imm      <= '0;
      ex_pc4      <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_dst      <= '0;
      stall_count <= '0;
    end else if (flush) begin
      ex_ctrl <= '0;
    end else if (stall) begin
      ex_ctrl <= '0;
      if (stall_count != '1) begin
        stall_count <= stall_count + CNT_W'(1);
      end
    end else begin
      ex_ctrl <= id_ctrl;
      ex_rd1  <= id_rd1;
      ex_rd2  <= id_rd2;
      ex_imm  <= id_imm;
      ex_pc4  <= id_pc4;
      ex_rs   <= id_rs;
      ex_rt   <= id_rt;
      ex_dst  <= dst_nxt;
    end
  end

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Purpose: directed table-driven check of the ID/EX register and hazard unit.
// Latency: outputs compared #1 after the rising edge; freeze signals mid-cycle.
// Backpressure: exercises load-use, jr, flush priority and counter saturation.
module tb_id_ex_hazard_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] id_ctrl;
  logic        id_is_jr;
  logic        id_uses_rt;
  logic [31:0] id_rd1;
  logic [31:0] id_rd2;
  logic [31:0] id_imm;
  logic [31:0] id_pc4;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic        flush;
  logic        mem_reg_write;
  logic        mem_mem_read;
  logic [4:0]  mem_dst;
  logic [10:0] ex_ctrl;
  logic [31:0] ex_rd1;
  logic [31:0] ex_rd2;
  logic [31:0] ex_imm;
  logic [31:0] ex_pc4;
  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;
  logic [4:0]  ex_dst;
  logic        pc_write;
  logic        if_id_write;
  logic [15:0] stall_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_hazard_reg #(
    .DATA_W(32),
    .RA_W  (5),
    .CNT_W (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .id_ctrl      (id_ctrl),
    .id_is_jr     (id_is_jr),
    .id_uses_rt   (id_uses_rt),
    .id_rd1       (id_rd1),
    .id_rd2       (id_rd2),
    .id_imm       (id_imm),
    .id_pc4       (id_pc4),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_rd        (id_rd),
    .flush        (flush),
    .mem_reg_write(mem_reg_write),
    .mem_mem_read (mem_mem_read),
    .mem_dst      (mem_dst),
    .ex_ctrl      (ex_ctrl),
    .ex_rd1       (ex_rd1),
    .ex_rd2       (ex_rd2),
    .ex_imm       (ex_imm),
    .ex_pc4       (ex_pc4),
    .ex_rs        (ex_rs),
    .ex_rt        (ex_rt),
    .ex_dst       (ex_dst),
    .pc_write     (pc_write),
    .if_id_write  (if_id_write),
    .stall_count  (stall_count)
  );

  // Control bundles: {rw, alu_src, mem_read, mem_write, m2r[1:0], rdst[1:0], alu[2:0]}
  localparam logic [10:0] C_NOP  = 11'h000;  // also jr
  localparam logic [10:0] C_ADD  = 11'h40A;  // R-type, reg_dst=rd
  localparam logic [10:0] C_LW   = 11'h722;  // load, reg_dst=rt
  localparam logic [10:0] C_JAL  = 11'h450;  // reg_dst=31
  localparam logic [10:0] C_ADDI = 11'h602;  // reg_dst=rt
  localparam logic [10:0] C_DST0 = 11'h41A;  // reg_dst=11 -> $0

  typedef struct {
    logic        rst;
    logic        flush;
    logic [10:0] ctrl;
    logic        is_jr;
    logic        uses_rt;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        mrw;
    logic        mmr;
    logic [4:0]  mdst;
    logic        chk_pcw;
    logic        e_pcw;
    logic [10:0] e_ctrl;
    logic [4:0]  e_dst;
    logic [4:0]  e_rs;
    logic [31:0] e_rd1;
    logic [15:0] e_cnt;
  } vec_t;

  localparam int NVEC = 21;
  vec_t vec [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input logic [31:0] seed);
    rst           = v.rst;
    flush         = v.flush;
    id_ctrl       = v.ctrl;
    id_is_jr      = v.is_jr;
    id_uses_rt    = v.uses_rt;
    id_rs         = v.rs;
    id_rt         = v.rt;
    id_rd         = v.rd;
    mem_reg_write = v.mrw;
    mem_mem_read  = v.mmr;
    mem_dst       = v.mdst;
    id_rd1        = seed;
    id_rd2        = ~seed;
    id_imm        = seed ^ 32'h0000_FFFF;
    id_pc4        = seed + 32'd4;
  endtask

  initial begin
    vec_t v;
    //              rst fl ctrl   jr ut rs  rt  rd  mrw mmr mdst cp ep e_ctrl e_dst e_rs e_rd1          e_cnt
    vec[0]  = '{1'b1,1'b0,C_LW,  1'b0,1'b1,5'd3, 5'd4, 5'd9, 1'b0,1'b0,5'd0, 1'b0,1'b1,C_NOP, 5'd0, 5'd0, 32'h0,         16'd0};
    vec[1]  = '{1'b1,1'b0,C_ADD, 1'b0,1'b1,5'd7, 5'd8, 5'd9, 1'b1,1'b1,5'd7, 1'b1,1'b1,C_NOP, 5'd0, 5'd0, 32'h0,         16'd0};
    // add $1,$2,$3
    vec[2]  = '{1'b0,1'b0,C_ADD, 1'b0,1'b1,5'd2, 5'd3, 5'd1, 1'b0,1'b0,5'd0, 1'b1,1'b1,C_ADD, 5'd1, 5'd2, 32'hA000_0002, 16'd0};
    // lw $5,0($4)
    vec[3]  = '{1'b0,1'b0,C_LW,  1'b0,1'b0,5'd4, 5'd5, 5'd0, 1'b0,1'b0,5'd0, 1'b1,1'b1,C_LW,  5'd5, 5'd4, 32'hA000_0003, 16'd0};
    // add $6,$5,$7 : load-use, one bubble
    vec[4]  = '{1'b0,1'b0,C_ADD, 1'b0,1'b1,5'd5, 5'd7, 5'd6, 1'b1,1'b0,5'd1, 1'b1,1'b0,C_NOP, 5'd5, 5'd4, 32'hA000_0003, 16'd1};
    vec[5]  = '{1'b0,1'b0,C_ADD, 1'b0,1'b1,5'd5, 5'd7, 5'd6, 1'b1,1'b1,5'd5, 1'b1,1'b1,C_ADD, 5'd6, 5'd5, 32'hA000_0005, 16'd1};
    // lw $0 then consumer of $0 : no stall
    vec[6]  = '{1'b0,1'b0,C_LW,  1'b0,1'b0,5'd4, 5'd0, 5'd0, 1'b0,1'b0,5'd0, 1'b1,1'b1,C_LW,  5'd0, 5'd4, 32'hA000_0006, 16'd1};
    vec[7]  = '{1'b0,1'b0,C_ADD, 1'b0,1'b1,5'd0, 5'd0, 5'd8, 1'b1,1'b0,5'd6, 1'b1,1'b1,C_ADD, 5'd8, 5'd0, 32'hA000_0007, 16'd1};
    // lw $31 then jr $31 : two bubbles
    vec[8]  = '{1'b0,1'b0,C_LW,  1'b0,1'b0,5'd4, 5'd31,5'd0, 1'b1,1'b1,5'd0, 1'b1,1'b1,C_LW,  5'd31,5'd4, 32'hA000_0008, 16'd1};
    vec[9]  = '{1'b0,1'b0,C_NOP, 1'b1,1'b0,5'd31,5'd0, 5'd0, 1'b1,1'b0,5'd8, 1'b1,1'b0,C_NOP, 5'd31,5'd4, 32'hA000_0008, 16'd2};
    vec[10] = '{1'b0,1'b0,C_NOP, 1'b1,1'b0,5'd31,5'd0, 5'd0, 1'b1,1'b1,5'd31,1'b1,1'b0,C_NOP, 5'd31,5'd4, 32'hA000_0008, 16'd3};
    vec[11] = '{1'b0,1'b0,C_NOP, 1'b1,1'b0,5'd31,5'd0, 5'd0, 1'b0,1'b0,5'd0, 1'b1,1'b1,C_NOP, 5'd0, 5'd31,32'hA000_000B, 16'd3};
    // lw $9 then add $10,$9,$9 with flush : flush beats stall
    vec[12] = '{1'b0,1'b0,C_LW,  1'b0,1'b0,5'd4, 5'd9, 5'd0, 1'b0,1'b0,5'd0, 1'b1,1'b1,C_LW,  5'd9, 5'd4, 32'hA000_000C, 16'd3};
    vec[13] = '{1'b0,1'b1,C_ADD, 1'b0,1'b1,5'd9, 5'd9, 5'd10,1'b0,1'b0,5'd0, 1'b1,1'b1,C_NOP, 5'd9, 5'd4, 32'hA000_000C, 16'd3};
    // jal -> dst 31, addi -> dst rt, reg_dst=11 -> dst 0
    vec[14] = '{1'b0,1'b0,C_JAL, 1'b0,1'b0,5'd0, 5'd0, 5'd0, 1'b0,1'b0,5'd0, 1'b1,1'b1,C_JAL, 5'd31,5'd0, 32'hA000_000E, 16'd3};
    vec[15] = '{1'b0,1'b0,C_ADDI,1'b0,1'b0,5'd31,5'd12,5'd0, 1'b1,1'b0,5'd0, 1'b1,1'b1,C_ADDI,5'd12,5'd31,32'hA000_000F, 16'd3};
    vec[16] = '{1'b0,1'b0,C_DST0,1'b0,1'b1,5'd1, 5'd2, 5'd3, 1'b1,1'b0,5'd31,1'b1,1'b1,C_DST0,5'd0, 5'd1, 32'hA000_0010, 16'd3};
    // add $7 then jr $7 : one bubble behind an ALU producer
    vec[17] = '{1'b0,1'b0,C_ADD, 1'b0,1'b1,5'd1, 5'd2, 5'd7, 1'b1,1'b0,5'd12,1'b1,1'b1,C_ADD, 5'd7, 5'd1, 32'hA000_0011, 16'd3};
    vec[18] = '{1'b0,1'b0,C_NOP, 1'b1,1'b0,5'd7, 5'd0, 5'd0, 1'b1,1'b0,5'd0, 1'b1,1'b0,C_NOP, 5'd7, 5'd1, 32'hA000_0011, 16'd4};
    vec[19] = '{1'b0,1'b0,C_NOP, 1'b1,1'b0,5'd7, 5'd0, 5'd0, 1'b1,1'b0,5'd7, 1'b1,1'b1,C_NOP, 5'd0, 5'd7, 32'hA000_0013, 16'd4};
    // jr $0 with a load to $0 in MEM : no hazard
    vec[20] = '{1'b0,1'b0,C_NOP, 1'b1,1'b0,5'd0, 5'd0, 5'd0, 1'b1,1'b1,5'd0, 1'b1,1'b1,C_NOP, 5'd0, 5'd0, 32'hA000_0014, 16'd4};

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vec[i], 32'hA000_0000 + 32'(i));
      #1;
      if (vec[i].chk_pcw) begin
        chk($sformatf("v%0d pc_write", i), 32'(pc_write), 32'(vec[i].e_pcw));
        chk($sformatf("v%0d if_id_write", i), 32'(if_id_write), 32'(vec[i].e_pcw));
      end
      @(posedge clk);
      #1;
      chk($sformatf("v%0d ex_ctrl", i), 32'(ex_ctrl), 32'(vec[i].e_ctrl));
      chk($sformatf("v%0d ex_dst", i), 32'(ex_dst), 32'(vec[i].e_dst));
      chk($sformatf("v%0d ex_rs", i), 32'(ex_rs), 32'(vec[i].e_rs));
      chk($sformatf("v%0d ex_rd1", i), ex_rd1, vec[i].e_rd1);
      chk($sformatf("v%0d stall_count", i), 32'(stall_count), 32'(vec[i].e_cnt));
    end

    // Continuous jr stall on a load in MEM, pushing the counter to 0xFFFE.
    @(negedge clk);
    v = '{1'b0,1'b0,C_NOP,1'b1,1'b0,5'd3,5'd0,5'd0,1'b1,1'b1,5'd3,1'b1,1'b0,C_NOP,5'd0,5'd0,32'h0,16'd0};
    drive(v, 32'h0);
    repeat (16'hFFFE - 16'd4) @(posedge clk);
    #1;
    chk("sat pre count", 32'(stall_count), 32'h0000_FFFE);
    chk("sat pre pc_write", 32'(pc_write), 32'd0);

    // Three load-use stalls: the first reaches all-ones, the rest must hold.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      v = '{1'b0,1'b0,C_LW,1'b0,1'b0,5'd4,5'd5,5'd0,1'b0,1'b0,5'd0,1'b1,1'b1,C_NOP,5'd0,5'd0,32'h0,16'd0};
      drive(v, 32'h0);
      @(negedge clk);
      v = '{1'b0,1'b0,C_ADD,1'b0,1'b1,5'd5,5'd7,5'd6,1'b0,1'b0,5'd0,1'b1,1'b1,C_NOP,5'd0,5'd0,32'h0,16'd0};
      drive(v, 32'h0);
      #1;
      chk($sformatf("sat%0d pc_write", k), 32'(pc_write), 32'd0);
      @(posedge clk);
      #1;
      chk($sformatf("sat%0d count", k), 32'(stall_count), 32'h0000_FFFF);
      chk($sformatf("sat%0d ex_ctrl", k), 32'(ex_ctrl), 32'(C_NOP));
    end

    // Full data path: every field reaches EX after one edge.
    @(negedge clk);
    v = '{1'b0,1'b0,C_ADD,1'b0,1'b1,5'd11,5'd12,5'd13,1'b0,1'b0,5'd0,1'b1,1'b1,C_NOP,5'd0,5'd0,32'h0,16'd0};
    drive(v, 32'h1234_5678);
    @(posedge clk);
    #1;
    chk("data ex_rd1", ex_rd1, 32'h1234_5678);
    chk("data ex_rd2", ex_rd2, 32'hEDCB_A987);
    chk("data ex_imm", ex_imm, 32'h1234_A987);
    chk("data ex_pc4", ex_pc4, 32'h1234_567C);
    chk("data ex_rt", 32'(ex_rt), 32'd12);
    chk("data ex_dst", 32'(ex_dst), 32'd13);
    chk("data count", 32'(stall_count), 32'h0000_FFFF);

    // Reset wins over a live hazard; freeze outputs still follow the hazard.
    @(negedge clk);
    v = '{1'b1,1'b0,C_NOP,1'b1,1'b0,5'd3,5'd0,5'd0,1'b1,1'b1,5'd3,1'b1,1'b0,C_NOP,5'd0,5'd0,32'h0,16'd0};
    drive(v, 32'h5555_AAAA);
    #1;
    chk("rst pc_write", 32'(pc_write), 32'd0);
    @(posedge clk);
    #1;
    chk("rst count", 32'(stall_count), 32'd0);
    chk("rst ex_rd2", ex_rd2, 32'd0);
    chk("rst ex_dst", 32'(ex_dst), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
